// File: rtl/phyreg_free_list.sv
// Free list of physical register tags for the rename stage: up to three tags
// granted per cycle, one reclaimed per cycle, self-initialised after reset.
module phyreg_free_list #(
    parameter int PHY_RF_DEPTH = 128,
    parameter int ALLOC_MAX    = 3,
    localparam int AW          = $clog2(PHY_RF_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ready,
    input  logic [1:0]                       alloc_num,
    output logic                             alloc_gnt,
    output logic [ALLOC_MAX-1:0][AW-1:0]     alloc_tags,
    input  logic                             rel_valid,
    input  logic [AW-1:0]                    rel_tag,
    output logic [AW:0]                      free_count,
    output logic                             low_free,
    output logic                             rel_err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW:0]   CAP       = (AW+1)'(PHY_RF_DEPTH - 1);
    localparam logic [AW:0]   LOW_MARK  = (AW+1)'(3);
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [AW-1:0] LAST_FILL = AW'(PHY_RF_DEPTH - 2);

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] fill_q, fill_d;
    logic [AW:0]   count_q, count_d;
    logic          rel_err_q, rel_err_d;

    logic [AW-1:0] mem [PHY_RF_DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] wr_data;

    logic          run;
    logic          rel_accept;
    logic [AW:0]   pop_cnt;
    logic [AW:0]   count_after_pop;

    always_comb begin
        run             = (state_q == S_RUN);
        alloc_gnt       = run && (alloc_num != 2'd0) &&
                          (count_q >= {{(AW-1){1'b0}}, alloc_num});
        pop_cnt         = alloc_gnt ? {{(AW-1){1'b0}}, alloc_num} : '0;
        count_after_pop = count_q - pop_cnt;
        // Capacity check uses the post-pop count so a same-cycle grant frees room.
        rel_accept      = run && rel_valid && (rel_tag != '0) && (count_after_pop < CAP);

        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        fill_d    = fill_q;
        count_d   = count_after_pop;
        rel_err_d = rel_valid && !rel_accept;
        wr_en     = 1'b0;
        wr_addr   = tail_q;
        wr_data   = rel_tag;

        if (alloc_gnt) begin
            head_d = head_q + {{(AW-2){1'b0}}, alloc_num};
        end

        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = fill_q;
                wr_data = fill_q + ONE_A;
                fill_d  = fill_q + ONE_A;
                tail_d  = tail_q + ONE_A;
                count_d = count_q + 1'b1;
                if (fill_q == LAST_FILL) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rel_accept) begin
                    wr_en   = 1'b1;
                    tail_d  = tail_q + ONE_A;
                    count_d = count_after_pop + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        for (int k = 0; k < ALLOC_MAX; k++) begin
            alloc_tags[k] = run ? mem[head_q + AW'(k)] : '0;
        end
        ready      = run;
        free_count = count_q;
        low_free   = (count_q < LOW_MARK);
        rel_err    = rel_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            head_q    <= '0;
            tail_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            rel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            rel_err_q <= rel_err_d;
        end
    end

    // Tag storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule
